aes_key_expander: RTL and testbench

Iterative AES key schedule that turns a cipher key of NK 32-bit words into the NR+1 round keys consumed by the cipher core. It computes one schedule word per clock and presents the full schedule as one flat bus. The bit layout matches the cipher's `ExpandedKeys` input, so the bus connects to it directly. The block sits directly upstream of the cipher and runs once per key change, not once per block.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_expander.sv | 165 ++++++++++++++++
 tb/tb_aes_key_expander.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, word type, key-expander FSM states,
// the forward S-box table and GF(2^8) doubling.
package aes_pkg;

    localparam int NB = 4;

    typedef logic [31:0] word_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } kexp_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES forward S-box byte substitution.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule, one word per clock, flat round-key bus output.
// Optional macro AES_KEYEXP_ZEROIZE_EN blanks the bus while key_valid is low.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*NK-1:0]      key,
    output logic                  busy,
    output logic                  done,
    output logic                  key_valid,
    output logic [128*(NR+1)-1:0] expanded_keys
);

    localparam int             TOTAL    = NB * (NR + 1);
    localparam int             IW       = $clog2(TOTAL);
    localparam logic [IW-1:0]  LAST_IDX = IW'(TOTAL - 1);
    localparam logic [IW-1:0]  NK_IDX   = IW'(NK);
    localparam logic [2:0]     P_LAST   = 3'(NK - 1);

    kexp_state_t    state_q, state_d;
    word_t          w_q [TOTAL];
    word_t          w_d [TOTAL];
    logic [IW-1:0]  i_q, i_d;
    logic [2:0]     p_q, p_d;
    logic [7:0]     rcon_q, rcon_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           kv_q, kv_d;

    logic [IW-1:0]  prev_idx_s;
    logic [IW-1:0]  back_idx_s;
    word_t          prev_s;
    word_t          back_s;
    word_t          sub_in_s;
    word_t          sub_out_s;
    word_t          temp_s;
    logic [32*TOTAL-1:0] flat_s;

    assign prev_idx_s = i_q - IW'(1);
    assign back_idx_s = i_q - NK_IDX;
    assign prev_s     = w_q[prev_idx_s];
    assign back_s     = w_q[back_idx_s];
    // RotWord only on the first word of each key-length group
    assign sub_in_s   = (p_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .data_i (sub_in_s[8*b +: 8]),
            .data_o (sub_out_s[8*b +: 8])
        );
    end

    // Select the transform applied to w[i-1] for this phase
    always_comb begin
        temp_s = prev_s;
        if (p_q == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_q, 24'h000000};
        end else if ((NK > 6) && (p_q == 3'd4)) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_s;
        end
    end

    // Next-state logic for FSM, counters and word array
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        i_d     = i_q;
        p_d     = p_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int k = 0; k < NK; k++) begin
                        w_d[k] = key[32*NK-1-32*k -: 32];
                    end
                    i_d     = NK_IDX;
                    p_d     = 3'd0;
                    rcon_d  = 8'h01;
                    busy_d  = 1'b1;
                    kv_d    = 1'b0;
                    state_d = ST_EXPAND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                w_d[i_q] = back_s ^ temp_s;
                i_d      = i_q + IW'(1);
                p_d      = (p_q == P_LAST) ? 3'd0 : p_q + 3'd1;
                if (p_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcon_d = rcon_q;
                end
                if (i_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXPAND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and word-array registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            p_q     <= 3'd0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
            for (int k = 0; k < TOTAL; k++) begin
                w_q[k] <= 32'h00000000;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            p_q     <= p_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
            for (int k = 0; k < TOTAL; k++) begin
                w_q[k] <= w_d[k];
            end
        end
    end

    // Word w[0] lands in the most significant 32 bits
    always_comb begin
        flat_s = '0;
        for (int j = 0; j < TOTAL; j++) begin
            flat_s[32*TOTAL-1-32*j -: 32] = w_q[j];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = kv_q;
`ifdef AES_KEYEXP_ZEROIZE_EN
    assign expanded_keys = kv_q ? flat_s : '0;
`else
    assign expanded_keys = flat_s;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed self-checking bench for aes_key_expander (AES-128 and AES-256 instances).
module tb_aes_key_expander;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK10_A1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK1_A1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_Z   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] RK1_Z    = 128'h62636363626363636263636362636363;

    logic           clk;
    logic           rst_n;
    logic           start128;
    logic [127:0]   key128;
    logic           busy128, done128, kv128;
    logic [1407:0]  ek128;
    logic           start256;
    logic [255:0]   key256;
    logic           busy256, done256, kv256;
    logic [1919:0]  ek256;

    int n_checks;
    int n_errors;
    int cyc;

    aes_key_expander #(.NR(10), .NK(4)) u_dut128 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start128),
        .key           (key128),
        .busy          (busy128),
        .done          (done128),
        .key_valid     (kv128),
        .expanded_keys (ek128)
    );

    aes_key_expander #(.NR(14), .NK(8)) u_dut256 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start256),
        .key           (key256),
        .busy          (busy256),
        .done          (done256),
        .key_valid     (kv256),
        .expanded_keys (ek256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] w128(input int j);
        return ek128[1407-32*j -: 32];
    endfunction

    function automatic logic [31:0] w256(input int j);
        return ek256[1919-32*j -: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit big, input int pulse_at, output int n);
        n = 0;
        while (((big ? done256 : done128) !== 1'b1) && (n < 200)) begin
            if (n == pulse_at) begin
                start128 = 1'b1;
                key128   = 128'h0;
            end
            step();
            start128 = 1'b0;
            n++;
        end
        check(big ? "done256_seen" : "done128_seen", {127'd0, (big ? done256 : done128)}, 128'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start128 = 1'b0;
        start256 = 1'b0;
        key128   = KEY_A1;
        key256   = KEY_A3;
        #12;
        check("rst_busy", {127'd0, busy128}, 128'd0);
        check("rst_done", {127'd0, done128}, 128'd0);
        check("rst_kv", {127'd0, kv128}, 128'd0);
        check("rst_ek_top", ek128[1407:1280], 128'd0);
        check("rst_kv256", {127'd0, kv256}, 128'd0);
        rst_n = 1'b1;
        step();

        // AES-128 A.1 with an ignored start at cycle 10 carrying a zero key
        start128 = 1'b1;
        key128   = KEY_A1;
        step();
        start128 = 1'b0;
        check("a1_busy_after_e0", {127'd0, busy128}, 128'd1);
        check("a1_kv_after_e0", {127'd0, kv128}, 128'd0);
        wait_done(1'b0, 10, cyc);
        check("a1_latency", 128'(cyc), 128'd40);
        check("a1_kv", {127'd0, kv128}, 128'd1);
        check("a1_busy_end", {127'd0, busy128}, 128'd0);
        check("a1_w4", w128(4), 128'h00000000000000000000000000a0fafe17 & 128'hffffffff);
        check("a1_rk0", ek128[1407:1280], KEY_A1);
        check("a1_rk1", ek128[1279:1152], RK1_A1);
        check("a1_rk10", ek128[127:0], RK10_A1);
        step();
        check("a1_done_pulse", {127'd0, done128}, 128'd0);
        check("a1_kv_hold", {127'd0, kv128}, 128'd1);

        // Mid-expansion visibility, then asynchronous reset at cycle 20
        start128 = 1'b1;
        key128   = KEY_A1;
        step();
        start128 = 1'b0;
        repeat (20) step();
        check("mid_kv", {127'd0, kv128}, 128'd0);
        check("mid_busy", {127'd0, busy128}, 128'd1);
`ifdef AES_KEYEXP_ZEROIZE_EN
        check("mid_top", ek128[1407:1280], 128'd0);
`else
        check("mid_top", ek128[1407:1280], KEY_A1);
`endif
        rst_n = 1'b0;
        #1;
        check("arst_busy", {127'd0, busy128}, 128'd0);
        check("arst_done", {127'd0, done128}, 128'd0);
        check("arst_kv", {127'd0, kv128}, 128'd0);
        check("arst_ek_rk1", ek128[1279:1152], 128'd0);
        #2;
        rst_n = 1'b1;
        step();
        start128 = 1'b1;
        key128   = KEY_A1;
        step();
        start128 = 1'b0;
        wait_done(1'b0, -1, cyc);
        check("rerun_latency", 128'(cyc), 128'd40);
        check("rerun_rk10", ek128[127:0], RK10_A1);

        // Back-to-back: start held in the done cycle with an all-zero key
        start128 = 1'b1;
        key128   = 128'h0;
        step();
        start128 = 1'b0;
        check("b2b_kv_drop", {127'd0, kv128}, 128'd0);
        check("b2b_busy", {127'd0, busy128}, 128'd1);
        check("b2b_done_low", {127'd0, done128}, 128'd0);
        wait_done(1'b0, -1, cyc);
        check("zero_latency", 128'(cyc), 128'd40);
        check("zero_rk0", ek128[1407:1280], 128'd0);
        check("zero_rk1", ek128[1279:1152], RK1_Z);
        check("zero_rk10", ek128[127:0], RK10_Z);

        // AES-256 A.3
        start256 = 1'b1;
        key256   = KEY_A3;
        step();
        start256 = 1'b0;
        check("a3_busy", {127'd0, busy256}, 128'd1);
        wait_done(1'b1, -1, cyc);
        check("a3_latency", 128'(cyc), 128'd52);
        check("a3_kv", {127'd0, kv256}, 128'd1);
        check("a3_w8", w256(8), 128'h9ba35411);
        check("a3_w12", w256(12), 128'ha8b09c1a);
        check("a3_w59", w256(59), 128'h706c631e);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
